// File: rtl/gpu_pkg.sv
// Shared core-scheduler and fetcher state encodings.
// The PC unit also imports core_state_t, so all eight core states live here.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/fetch_line_buffer.sv
// One-entry last-fetch buffer: remembers the most recent memory fill so that
// re-fetching the same PC needs no memory round trip.
module fetch_line_buffer #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 i_flush,
  input  logic                 i_fill,
  input  logic [ADDR_BITS-1:0] i_fill_addr,
  input  logic [DATA_BITS-1:0] i_fill_data,
  input  logic [ADDR_BITS-1:0] i_lookup_addr,
  output logic                 o_hit,
  output logic [DATA_BITS-1:0] o_data
);

  logic                 r_valid;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_data;

  // A fill beats a simultaneous flush: the returned word is fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (enable) begin
      if (i_fill) begin
        r_valid <= 1'b1;
        r_addr  <= i_fill_addr;
        r_data  <= i_fill_data;
      end else if (i_flush) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_hit  = r_valid && (r_addr == i_lookup_addr);
  assign o_data = r_data;

endmodule

// File: rtl/instr_fetch_unit.sv
// Per-core instruction fetcher: reads program memory at current_pc over a
// valid/ready channel, or serves a repeat fetch from the last-fetch buffer.
module instr_fetch_unit
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_hit
);

  fetcher_state_t                   r_state, w_state_nxt;
  logic                             r_mem_valid, w_mem_valid_nxt;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr, w_instr_nxt;
  logic                             r_hit, w_hit_nxt;
  logic                             w_fill;
  logic                             w_buf_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_buf_data;

  fetch_line_buffer #(
    .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS(PROGRAM_MEM_DATA_BITS)
  ) u_line_buffer (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .i_flush      (flush),
    .i_fill       (w_fill),
    .i_fill_addr  (r_mem_addr),
    .i_fill_data  (mem_read_data),
    .i_lookup_addr(current_pc),
    .o_hit        (w_buf_hit),
    .o_data       (w_buf_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FETCHER_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_instr     <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_instr     <= w_instr_nxt;
      r_hit       <= w_hit_nxt;
    end
  end

  // fetch_hit is a pulse, so it defaults low rather than holding.
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_addr_nxt  = r_mem_addr;
    w_instr_nxt     = r_instr;
    w_hit_nxt       = 1'b0;
    w_fill          = 1'b0;
    if (enable) begin
      case (r_state)
        FETCHER_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (w_buf_hit && !flush) begin
              w_instr_nxt = w_buf_data;
              w_hit_nxt   = 1'b1;
              w_state_nxt = FETCHER_FETCHED;
            end else begin
              w_mem_valid_nxt = 1'b1;
              w_mem_addr_nxt  = current_pc;
              w_state_nxt     = FETCHER_FETCHING;
            end
          end
        end
        FETCHER_FETCHING: begin
          if (mem_read_ready) begin
            w_mem_valid_nxt = 1'b0;
            w_instr_nxt     = mem_read_data;
            w_fill          = 1'b1;
            w_state_nxt     = FETCHER_FETCHED;
          end
        end
        FETCHER_FETCHED: begin
          if (core_state == CORE_DECODE) w_state_nxt = FETCHER_IDLE;
        end
        default: w_state_nxt = FETCHER_IDLE;
      endcase
    end
  end

  assign mem_read_valid   = r_mem_valid;
  assign mem_read_address = r_mem_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign fetch_hit        = r_hit;

endmodule
